// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per cycle, with a fast path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            rd_wren,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  // state | meaning
  // IDLE  | waiting for a request
  // CALC  | 32 restoring-division iterations
  // DONE  | result presented, write-back strobe
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t          state, state_nxt;
  logic            accept;
  logic            rem_sel_q, q_neg_q, r_neg_q;
  logic [4:0]      dst_q, cnt_q;
  logic [XLEN-1:0] dvd_q, dsr_q, rem_q;

  logic            op_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;
  logic [XLEN:0]   trial;
  logic            borrow;
  logic [XLEN-1:0] rem_nxt, quo_nxt, fin_res;

  always_comb begin
    op_signed = ~div_op[0];
    a_neg     = op_signed & rs1_data[XLEN-1];
    b_neg     = op_signed & rs2_data[XLEN-1];
    abs_a     = a_neg ? -rs1_data : rs1_data;
    abs_b     = b_neg ? -rs2_data : rs2_data;
    div_zero  = (rs2_data == '0);
    ovf       = op_signed && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
    special   = div_zero | ovf;
    if (div_zero) spec_res = div_op[1] ? rs1_data : ALL_ONES;
    else          spec_res = div_op[1] ? '0 : MIN_NEG;
  end

  // 33-bit trial subtract: the shifted partial remainder can exceed XLEN bits
  always_comb begin
    trial   = {rem_q, dvd_q[XLEN-1]} - {1'b0, dsr_q};
    borrow  = trial[XLEN];
    rem_nxt = borrow ? {rem_q[XLEN-2:0], dvd_q[XLEN-1]} : trial[XLEN-1:0];
    quo_nxt = {dvd_q[XLEN-2:0], ~borrow};
    if (rem_sel_q) fin_res = r_neg_q ? -rem_nxt : rem_nxt;
    else           fin_res = q_neg_q ? -quo_nxt : quo_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (div_valid && !flush) begin
        accept    = 1'b1;
        state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        if (flush)            state_nxt = IDLE;
        else if (cnt_q == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dst_q     <= '0;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else if (accept) begin
      rem_sel_q <= div_op[1];
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      dst_q     <= rd_addr_in;
      cnt_q     <= 5'd31;
      dvd_q     <= abs_a;
      dsr_q     <= abs_b;
      rem_q     <= '0;
      if (special) begin
        rd_addr <= rd_addr_in;
        rd_data <= spec_res;
      end
    end else if (state == CALC && !flush) begin
      dvd_q <= quo_nxt;
      rem_q <= rem_nxt;
      if (cnt_q == '0) begin
        rd_addr <= dst_q;
        rd_data <= fin_res;
      end else begin
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign rd_wren = (state == DONE) && !flush && (rd_addr != '0);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected write-backs, a monitor pops and compares.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_valid = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        flush = 1'b0;
  logic        busy, rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_op(div_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in), .flush(flush),
    .busy(busy), .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wren_cnt = 0;
  int wcyc = 0;
  int acc = 0;
  int w0 = 0;
  logic [36:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_wren === 1'b1) begin
      wcyc = cyc;
      wren_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: rd_addr=%0d rd_data=0x%08h with empty scoreboard", rd_addr, rd_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_addr", {27'd0, rd_addr}, {27'd0, e[36:32]});
        chk("wb_data", rd_data, e[31:0]);
      end
    end
  end

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_d, input bit push);
    @(negedge clk);
    div_valid  = 1'b1;
    div_op     = op;
    rs1_data   = a;
    rs2_data   = b;
    rd_addr_in = rd;
    if (push && rd != 5'd0) exp_q.push_back({rd, exp_d});
    w0 = wren_cnt;
    @(posedge clk);
    #1;
    acc = cyc;
    div_valid = 1'b0;
  endtask

  task automatic finish_op(input logic [4:0] rd, input int exp_busy, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      if (hold) begin
        div_valid  = 1'b1;
        div_op     = 2'($urandom_range(0, 3));
        rs1_data   = $urandom;
        rs2_data   = $urandom;
        rd_addr_in = 5'($urandom_range(1, 31));
      end
      @(negedge clk);
    end
    div_valid = 1'b0;
    chk("busy_len", n, exp_busy);
    if (rd != 5'd0) begin
      chk("wren_count", wren_cnt - w0, 1);
      chk("latency", wcyc - acc, exp_busy - 1);
    end else begin
      chk("wren_suppressed", wren_cnt - w0, 0);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp_d, input int exp_busy);
    start(op, a, b, rd, exp_d, 1'b1);
    finish_op(rd, exp_busy, 1'b0);
  endtask

  initial begin
    int wbase;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wren", {31'd0, rd_wren}, 0);
    chk("rst_addr", {27'd0, rd_addr}, 0);
    chk("rst_data", rd_data, 0);
    rst = 1'b0;

    run(OP_DIV,  32'd100, 32'd7, 5'd5, 32'd14, 33);
    run(OP_REM,  32'd100, 32'd7, 5'd6, 32'd2, 33);
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33);
    run(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
    run(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, 33);
    run(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'h7FFF_FFFC, 33);
    run(OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33);
    run(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd10, 32'd1, 33);
    run(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, 32'h7FFF_FFFE, 33);
    run(OP_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run(OP_REM,  32'd5, 32'd0, 5'd13, 32'd5, 1);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 33);

    // flush on the 10th CALC cycle, then a fresh request the following cycle
    wbase = wren_cnt;
    start(OP_DIV, 32'd100, 32'd7, 5'd17, 32'd14, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 0);
    run(OP_DIVU, 32'd9, 32'd3, 5'd18, 32'd3, 33);
    repeat (40) @(negedge clk);
    chk("flush_no_wb", wren_cnt - wbase, 1);

    // request held with changing operands while busy is ignored
    start(OP_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b1);
    finish_op(5'd7, 33, 1'b1);

    run(OP_DIV, 32'd50, 32'd5, 5'd0, 32'd10, 33);

    // reset in the middle of CALC
    wbase = wren_cnt;
    start(OP_DIV, 32'd100, 32'd7, 5'd19, 32'd14, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_wren", {31'd0, rd_wren}, 0);
    chk("midrst_addr", {27'd0, rd_addr}, 0);
    chk("midrst_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_wb", wren_cnt - wbase, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
